// File: rtl/cu_pkg.sv
// Shared decode constants for the RV32I main control unit
// and the ALU-control block.
package cu_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  typedef struct packed {
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
    logic       jalr;
    logic [1:0] alu_op;
  } ctrl_t;

endpackage

// File: rtl/cu.sv
// Main control unit: combinational opcode decode plus a
// sticky flag recording any unsupported opcode.
module cu
  import cu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  output logic       ALUSrc,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       Branch,
  output logic       Jump,
  output logic       Jalr,
  output logic [1:0] ALUOp,
  output logic       illegal,
  output logic       illegal_seen
);

  ctrl_t ctrl;
  logic  illegal_seen_d;
  logic  illegal_seen_q;

  // Unknown opcodes decode to an all-zero NOP so nothing is written.
  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    case (opcode)
      OP_R: begin
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALUOP_R;
      end
      OP_LOAD: begin
        ctrl.alu_src    = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.alu_op     = ALUOP_ADD;
      end
      OP_JALR: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.jalr      = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
      end
      OP_IMM: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = ALUOP_I;
      end
      OP_STORE: begin
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
      end
      OP_BRANCH: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = ALUOP_BR;
      end
      OP_JAL: begin
        ctrl.reg_write = 1'b1;
        ctrl.jump      = 1'b1;
        ctrl.alu_op    = ALUOP_ADD;
      end
      default: begin
        ctrl    = '0;
        illegal = 1'b1;
      end
    endcase
  end

  assign ALUSrc   = ctrl.alu_src;
  assign MemtoReg = ctrl.mem_to_reg;
  assign RegWrite = ctrl.reg_write;
  assign MemRead  = ctrl.mem_read;
  assign MemWrite = ctrl.mem_write;
  assign Branch   = ctrl.branch;
  assign Jump     = ctrl.jump;
  assign Jalr     = ctrl.jalr;
  assign ALUOp    = ctrl.alu_op;

  assign illegal_seen_d = illegal_seen_q | illegal;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) illegal_seen_q <= 1'b0;
    else        illegal_seen_q <= illegal_seen_d;
  end

  assign illegal_seen = illegal_seen_q;

endmodule

// File: tb/tb_cu.sv
// Directed and exhaustive bench for cu, scoreboard-checked
// against an opcode table written from the decode rules.
module tb_cu;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic       ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite;
  logic       Branch, Jump, Jalr, illegal, illegal_seen;
  logic [1:0] ALUOp;

  cu dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .opcode       (opcode),
    .ALUSrc       (ALUSrc),
    .MemtoReg     (MemtoReg),
    .RegWrite     (RegWrite),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .Branch       (Branch),
    .Jump         (Jump),
    .Jalr         (Jalr),
    .ALUOp        (ALUOp),
    .illegal      (illegal),
    .illegal_seen (illegal_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [10:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  n_total = 0;
  int  n_pass  = 0;
  int  n_legal = 0;

  // {ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,Jump,Jalr,ALUOp,illegal}
  function automatic logic [10:0] model(input logic [6:0] op);
    if (op == 7'b0110011) return 11'b0010_0000_10_0;
    if (op == 7'b0000011) return 11'b1111_0000_00_0;
    if (op == 7'b1100111) return 11'b1010_0001_00_0;
    if (op == 7'b0010011) return 11'b1010_0000_11_0;
    if (op == 7'b0100011) return 11'b1000_1000_00_0;
    if (op == 7'b1100011) return 11'b0000_0100_01_0;
    if (op == 7'b1101111) return 11'b0010_0010_00_0;
    return 11'b0000_0000_00_1;
  endfunction

  function automatic logic [10:0] observed();
    return {ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite,
            Branch, Jump, Jalr, ALUOp, illegal};
  endfunction

  task automatic check_bit(input string tag, input logic obs,
                           input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  task automatic drive_op(input logic [6:0] op, input string tag);
    sb_t e;
    sb_t got;
    logic [10:0] obs;
    opcode = op;
    e.tag = tag;
    e.exp = model(op);
    sb_q.push_back(e);
    #1;
    obs = observed();
    n_total++;
    if (sb_q.size() == 0) begin
      $error("FAIL %s scoreboard empty observed=%b expected=entry",
             tag, obs);
    end else begin
      got = sb_q.pop_front();
      assert (obs === got.exp) n_pass++;
      else $error("FAIL %s observed=%b expected=%b",
                  got.tag, obs, got.exp);
    end
  endtask

  initial begin
    opcode = 7'b0110011;
    rst_n  = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check_bit("reset_seen", illegal_seen, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    drive_op(7'b0110011, "rtype");
    drive_op(7'b0000011, "load");
    drive_op(7'b0100011, "store");
    drive_op(7'b1100111, "jalr");
    drive_op(7'b1101111, "jal");
    drive_op(7'b1100011, "branch");
    drive_op(7'b0010011, "itype");
    @(posedge clk);
    #1;
    check_bit("legal_no_seen", illegal_seen, 1'b0);

    @(negedge clk);
    drive_op(7'b0110111, "lui");
    check_bit("lui_seen_before_edge", illegal_seen, 1'b0);
    @(posedge clk);
    #1;
    check_bit("lui_seen", illegal_seen, 1'b1);

    drive_op(7'b0110011, "rtype_after");
    @(posedge clk);
    #1;
    check_bit("seen_sticky", illegal_seen, 1'b1);

    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_bit("async_clear", illegal_seen, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_bit("stay_clear", illegal_seen, 1'b0);

    @(negedge clk);
    opcode = 7'b0010111;
    rst_n  = 1'b0;
    @(posedge clk);
    #1;
    check_bit("held_in_reset", illegal_seen, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_bit("release_pre_edge", illegal_seen, 1'b0);
    @(posedge clk);
    #1;
    check_bit("release_first_edge", illegal_seen, 1'b1);

    for (int i = 0; i < 128; i++) begin
      drive_op(7'(i), $sformatf("sweep_%0d", i));
      if (!illegal) n_legal++;
      check_bit($sformatf("rdwr_%0d", i), MemRead & MemWrite, 1'b0);
      check_bit($sformatf("onehot_%0d", i),
                $countones({Branch, Jump, Jalr}) <= 1, 1'b1);
    end
    n_total++;
    assert (n_legal == 7) n_pass++;
    else $error("FAIL legal_count observed=%0d expected=7", n_legal);

    n_total++;
    assert (sb_q.size() == 0) n_pass++;
    else $error("FAIL sb_drain observed=%0d expected=0", sb_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
